conv_result_writer: RTL and testbench
=====================================

// Module: conv_result_writer
// PURPOSE
//  Downstream consumer of the Conv2d result stream (out[35:0] qualified by en). Requantizes each
//  36-bit accumulator to a 9-bit signed pixel with runtime shift, rounding and saturation. Buffers
//  pixels in a small FIFO and presents them on a valid/ready stream with raster end-of-line/frame
//  markers. The output pixel format matches the Conv2d x input, so layers can be chained.
// PARAMETERS
//  OUT_W       126  valid output columns per row (image width - 2)
//  OUT_H       126  valid output rows per frame (image height - 2)
//  FIFO_DEPTH  4    output FIFO entries; power of two, >= 2
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   synchronous reset, active-low
//  in_en      in   1   in_res valid this cycle; no backpressure to the producer
//  in_res     in   36  signed convolution accumulator
//  shift      in   5   right-shift amount 0..31; held static during a frame
//  out_valid  out  1   out_pix/out_eol/out_eof valid
//  out_ready  in   1   consumer accepts the current pixel
//  out_pix    out  9   signed requantized pixel
//  out_eol    out  1   current pixel is the last column of a row
//  out_eof    out  1   current pixel is the last pixel of the frame
//  overflow   out  1   sticky: a pixel was dropped because the FIFO was full
//  sat_cnt    out  16  count of saturated pixels, saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset (rst==0 at a clk edge): FIFO emptied, stage valid=0, col/row=0, overflow=0, sat_cnt=0.
//    All outputs read 0 the following cycle. Reset mid-frame discards all in-flight data.
//  - Stage 1 (registered, 1 cycle): r = (shift==0) ? in_res : (in_res + (1<<(shift-1))) >>> shift,
//    computed at 37 bits so the add cannot wrap. Clamp to [-256, 255]. If the clamp changes the
//    value, sat_cnt increments when the stage register loads.
//  - Stage 2: the stage-1 result is pushed into the FIFO on the cycle after in_en.
//    Latency from in_en to out_valid = 2 cycles when the FIFO is empty.
//  - The FIFO is first-word-fall-through: out_valid = !empty, and out_pix shows the head entry.
//    A pop occurs when out_valid && out_ready.
//  - Push while full with no pop that cycle: the pixel is dropped, overflow is set, and it stays
//    set until reset. Push while full with a pop the same cycle is legal and drops nothing.
//  - Raster counters col/row advance on each pop only. out_eol = (col==OUT_W-1).
//    out_eof = out_eol && (row==OUT_H-1).
//  - Counter wrap: col wraps to 0 and row increments on the eol pop; both wrap to 0 on the eof pop.
//  - Dropped pixels do not advance the counters; after an overflow, eol/eof alignment is undefined
//    until reset.
//  - Outputs out_pix/eol/eof are held stable while out_valid && !out_ready.
// CONFIGURATION
//  CONV_RELU_EN defined: after the clamp, negative results become 0. A negative value forced to 0
//    by this rule is not counted in sat_cnt. out_pix is therefore always in [0, 255].
//  CONV_RELU_EN undefined: pixels are signed, in [-256, 255].
// STRUCTURE
//  - conv_pkg: RES_W=36, PIX_W=9, PIX_MAX=255, PIX_MIN=-256, SHIFT_W=5, and the clamp function.
//  - Sub-module sync_fifo (WIDTH=PIX_W, DEPTH=FIFO_DEPTH; full/empty flags; FWFT read).
//  - The top level holds stage 1, the overflow/sat logic and the raster counters.
// TESTING
//  1. shift=4, in_res=100 -> out_pix=6. in_res=-100 -> out_pix=-6 (ReLU off) or 0 (ReLU on).
//  2. shift=0, in_res=10000 -> 255, sat_cnt=1; in_res=-10000 -> -256, sat_cnt=2 (ReLU off).
//  3. OUT_W=4, OUT_H=2, 8 pushes, out_ready=1 -> eol on pixels 4 and 8, eof only on pixel 8;
//     pixel 9 has col=0, row=0.
//  4. out_ready=0, 5 consecutive pushes, FIFO_DEPTH=4 -> 4 pixels drained in order, overflow=1,
//     5th dropped.
//  5. FIFO full, push and pop in the same cycle -> no drop, overflow stays 0.
//  6. rst=0 mid-frame with FIFO holding 3 pixels -> next cycle out_valid=0, sat_cnt=0;
//     the next push emits with col=0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared widths, pixel range and the requantizer clamp for the Conv2d
// result path.
//   RES_W   : width of the signed convolution accumulator
//   PIX_W   : width of the signed output pixel (same as the Conv2d x input)
//   SHIFT_W : width of the runtime right-shift control
//   clamp_pix() narrows a (RES_W+1)-bit signed value to a pixel in
//   [PIX_MIN, PIX_MAX] and flags whether the value had to be clipped.
package conv_pkg;

  localparam int RES_W   = 36;
  localparam int PIX_W   = 9;
  localparam int SHIFT_W = 5;

  localparam logic signed [PIX_W-1:0] PIX_MAX = 9'h0FF;  //  255
  localparam logic signed [PIX_W-1:0] PIX_MIN = 9'h100;  // -256

  typedef struct packed {
    logic                    sat;
    logic signed [PIX_W-1:0] pix;
  } clamp_t;

  function automatic clamp_t clamp_pix(input logic signed [RES_W:0] v);
    clamp_t                  c;
    logic signed [RES_W:0]   hi;
    logic signed [RES_W:0]   lo;
    hi = {{(RES_W+1-PIX_W){PIX_MAX[PIX_W-1]}}, PIX_MAX};
    lo = {{(RES_W+1-PIX_W){PIX_MIN[PIX_W-1]}}, PIX_MIN};
    if (v > hi) begin
      c.sat = 1'b1;
      c.pix = PIX_MAX;
    end else if (v < lo) begin
      c.sat = 1'b1;
      c.pix = PIX_MIN;
    end else begin
      c.sat = 1'b0;
      c.pix = v[PIX_W-1:0];
    end
    return c;
  endfunction

endpackage

// File: rtl/conv_result_writer_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk   : clock, rising edge
//   rst   : synchronous reset, active-low (empties the FIFO)
//   push  : write din this cycle (ignored when full unless pop is also high)
//   pop   : consume the head entry (ignored when empty)
//   din   : write data
//   dout  : head entry, valid whenever empty==0
//   full  : DEPTH entries held
//   empty : no entries held
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             wr;
  logic             rd;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign dout  = mem[rd_ptr];

  // A push into a full FIFO is accepted only when the head leaves the same cycle.
  assign wr = push && (!full || pop);
  assign rd = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/conv_result_writer.sv
// conv_result_writer: requantizes the Conv2d accumulator stream to signed
// 9-bit pixels (round-half-up shift, saturating clamp), buffers them in a
// FWFT FIFO and presents them on a valid/ready stream with raster
// end-of-line / end-of-frame markers.
//   clk       : clock, rising edge
//   rst       : synchronous reset, active-low
//   in_en     : in_res valid this cycle (no backpressure)
//   in_res    : signed 36-bit accumulator
//   shift     : right-shift amount 0..31, static within a frame
//   out_valid : out_pix/out_eol/out_eof valid
//   out_ready : consumer accepts the current pixel
//   out_pix   : signed requantized pixel
//   out_eol   : last column of a row
//   out_eof   : last pixel of the frame
//   overflow  : sticky, a pixel was dropped on a full FIFO
//   sat_cnt   : saturated-pixel count, sticks at 16'hFFFF
// Build option: define CONV_RELU_EN to zero negative pixels after the clamp.
module conv_result_writer
  import conv_pkg::*;
#(
  parameter int OUT_W      = 126,
  parameter int OUT_H      = 126,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_en,
  input  logic signed [RES_W-1:0]   in_res,
  input  logic        [SHIFT_W-1:0] shift,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [PIX_W-1:0]   out_pix,
  output logic                      out_eol,
  output logic                      out_eof,
  output logic                      overflow,
  output logic        [15:0]        sat_cnt
);

  localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int RW = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  logic signed [RES_W:0]   ext_s;
  logic signed [RES_W:0]   rnd_s;
  logic signed [RES_W:0]   sum_s;
  logic signed [RES_W:0]   shr_s;
  clamp_t                  q_s;

  logic signed [PIX_W-1:0] pix_p1;
  logic                    vld_p1;

  logic [PIX_W-1:0]        fifo_dout;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    pop;

  logic [CW-1:0]           col;
  logic [RW-1:0]           row;
  logic                    is_eol;
  logic                    is_eof;

  // The extra accumulator bit keeps the rounding add from wrapping.
  // A zero shift adds nothing and shifts by nothing, so one formula covers it.
  always_comb begin
    ext_s = {in_res[RES_W-1], in_res};
    rnd_s = '0;
    if (shift != '0) rnd_s = {{RES_W{1'b0}}, 1'b1} << (shift - 1'b1);
    sum_s = ext_s + rnd_s;
    shr_s = sum_s >>> shift;
    q_s   = clamp_pix(shr_s);
`ifdef CONV_RELU_EN
    if (q_s.pix[PIX_W-1]) q_s.pix = '0;
`endif
  end

  // ---- stage 1: requantized pixel register ----
  always_ff @(posedge clk) begin
    if (!rst) vld_p1 <= 1'b0;
    else      vld_p1 <= in_en;
  end

  always_ff @(posedge clk) begin
    if (in_en) pix_p1 <= q_s.pix;
  end

  always_ff @(posedge clk) begin
    if (!rst)                                  sat_cnt <= '0;
    else if (in_en && q_s.sat && sat_cnt != '1) sat_cnt <= sat_cnt + 1'b1;
  end

  // ---- stage 2: FIFO push and output stream ----
  assign pop = out_valid && out_ready;

  sync_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_p1),
    .pop   (pop),
    .din   (pix_p1),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst)                           overflow <= 1'b0;
    else if (vld_p1 && fifo_full && !pop) overflow <= 1'b1;
  end

  // Raster position of the FIFO head; only pops move it.
  assign is_eol = (col == CW'(OUT_W - 1));
  assign is_eof = is_eol && (row == RW'(OUT_H - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (pop) begin
      if (is_eof) begin
        col <= '0;
        row <= '0;
      end else if (is_eol) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Stream outputs read zero whenever nothing is presented.
  assign out_valid = !fifo_empty;
  assign out_pix   = out_valid ? $signed(fifo_dout) : '0;
  assign out_eol   = out_valid && is_eol;
  assign out_eof   = out_valid && is_eof;

endmodule

// File: tb/tb_conv_result_writer.sv
module tb_conv_result_writer;
  import conv_pkg::*;

  localparam int OUT_W      = 4;
  localparam int OUT_H      = 2;
  localparam int FIFO_DEPTH = 4;

  logic                      clk;
  logic                      rst;
  logic                      in_en;
  logic signed [RES_W-1:0]   in_res;
  logic        [SHIFT_W-1:0] shift;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [PIX_W-1:0]   out_pix;
  logic                      out_eol;
  logic                      out_eof;
  logic                      overflow;
  logic        [15:0]        sat_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  conv_result_writer #(
    .OUT_W      (OUT_W),
    .OUT_H      (OUT_H),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_en     (in_en),
    .in_res    (in_res),
    .shift     (shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pix   (out_pix),
    .out_eol   (out_eol),
    .out_eof   (out_eof),
    .overflow  (overflow),
    .sat_cnt   (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got running, need finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, need %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_en = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // One-cycle in_en pulse; returns on the negedge after the stage-1 load.
  task automatic send(input int val);
    in_en  = 1'b1;
    in_res = RES_W'(val);
    @(negedge clk);
    in_en  = 1'b0;
  endtask

  task automatic pop_check(input string tag, input int exp);
    check({tag, ".valid"}, int'(out_valid), 1);
    check({tag, ".pix"}, $signed(out_pix), exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  int neg6;
  int neg256;
  int neg1;

  initial begin
    rst = 1'b0; in_en = 1'b0; in_res = '0; shift = '0; out_ready = 1'b0;
`ifdef CONV_RELU_EN
    neg6 = 0; neg256 = 0; neg1 = 0;
`else
    neg6 = -6; neg256 = -256; neg1 = -1;
`endif
    @(negedge clk);
    do_reset();
    check("rst.valid", int'(out_valid), 0);
    check("rst.pix", int'(out_pix), 0);
    check("rst.eol", int'(out_eol), 0);
    check("rst.eof", int'(out_eof), 0);
    check("rst.ovf", int'(overflow), 0);
    check("rst.sat", int'(sat_cnt), 0);

    // rounding shift, latency 2
    shift = 5'd4;
    send(100);
    check("lat.valid_c1", int'(out_valid), 0);
    send(-100);
    check("lat.valid_c2", int'(out_valid), 1);
    shift = 5'd1;
    send(3);
    send(-3);
    @(negedge clk);
    check("rnd.ovf", int'(overflow), 0);
    check("rnd.sat", int'(sat_cnt), 0);
    pop_check("rnd.p100", 6);
    pop_check("rnd.m100", neg6);
    pop_check("rnd.p3", 2);
    pop_check("rnd.m3", neg1);
    check("rnd.empty", int'(out_valid), 0);

    // saturation at both rails, exact rails not counted
    do_reset();
    shift = 5'd0;
    send(10000);
    check("sat.cnt1", int'(sat_cnt), 1);
    send(-10000);
    check("sat.cnt2", int'(sat_cnt), 2);
    send(255);
    send(-256);
    @(negedge clk);
    check("sat.cnt_rail", int'(sat_cnt), 2);
    pop_check("sat.hi", 255);
    pop_check("sat.lo", neg256);
    pop_check("sat.255", 255);
    pop_check("sat.m256", neg256);

    // raster markers, ready held high
    do_reset();
    shift = 5'd0;
    out_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      if (t >= 2 && t <= 10) begin
        check($sformatf("ras.valid%0d", t - 2), int'(out_valid), 1);
        check($sformatf("ras.pix%0d", t - 2), $signed(out_pix), t - 1);
        check($sformatf("ras.eol%0d", t - 2), int'(out_eol), ((t - 2) % 4 == 3) ? 1 : 0);
        check($sformatf("ras.eof%0d", t - 2), int'(out_eof), (t - 2 == 7) ? 1 : 0);
      end
      in_en  = (t < 9);
      in_res = RES_W'(t + 1);
      @(negedge clk);
    end
    in_en = 1'b0;
    out_ready = 1'b0;
    check("ras.drained", int'(out_valid), 0);

    // overflow: 5 pushes into a depth-4 FIFO with no pops
    do_reset();
    shift = 5'd0;
    for (int i = 0; i < 5; i++) send(11 + i);
    @(negedge clk);
    check("ovf.flag", int'(overflow), 1);
    for (int i = 0; i < 4; i++) pop_check($sformatf("ovf.p%0d", i), 11 + i);
    check("ovf.dropped", int'(out_valid), 0);
    check("ovf.sticky", int'(overflow), 1);

    // push and pop on the same cycle while full
    do_reset();
    shift = 5'd0;
    for (int i = 0; i < 4; i++) send(21 + i);
    @(negedge clk);
    send(25);
    out_ready = 1'b1;   // pop coincides with the push of 25
    @(negedge clk);
    out_ready = 1'b0;
    check("full.ovf", int'(overflow), 0);
    for (int i = 0; i < 4; i++) pop_check($sformatf("full.p%0d", i), 22 + i);
    check("full.empty", int'(out_valid), 0);

    // reset mid-frame discards data and restarts the raster
    do_reset();
    shift = 5'd0;
    for (int i = 0; i < 4; i++) send(1000 + i);
    @(negedge clk);
    pop_check("mid.first", 255);
    check("mid.sat", int'(sat_cnt), 4);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mid.valid", int'(out_valid), 0);
    check("mid.sat0", int'(sat_cnt), 0);
    check("mid.ovf0", int'(overflow), 0);
    for (int i = 0; i < 4; i++) send(40 + i);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mid.eol%0d", i), int'(out_eol), 0);
      pop_check($sformatf("mid.p%0d", i), 40 + i);
    end
    check("mid.eol3", int'(out_eol), 1);
    pop_check("mid.p3", 43);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
